id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register for the 5-stage RV32I core, with load-use hazard detection and bubble insertion. It captures the decode-stage control word and operands produced by `control`, plus register indices and PC, and presents them registered to the EX stage. It raises a stall to IF/ID and the PC when a decoded instruction needs the result of a load still in EX. It accepts flushes from branch/jump resolution and holds state under downstream stall.

## Interface
Parameters:
- `XLEN`, 32, datapath width of operand, PC and immediate fields.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_optype`  in  11  one-hot class: bit0 R, bit1 I-ALU, bit2 load, bit3 store, bit4 branch, bit5 JAL, bit6 JALR, bit7 LUI, bit8 AUIPC, bit9 system.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_pc`  in  XLEN  instruction PC.
- `id_alu_op`  in  4  ALU operation.
- `id_alu_src`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`, `id_branch`, `id_jump`, `id_jalr`  in  1 each  control bits.
- `id_x`, `id_y`, `id_write_data`, `id_imm`  in  XLEN each  operands, store data, immediate.
- `flush`  in  1  kill the instruction entering EX (taken branch/jump).
- `ex_stall`  in  1  EX/MEM cannot accept; hold the register.
- `ex_*`  out  matching widths  registered copies of every `id_*` field above (`ex_valid` … `ex_imm`).
- `hazard_stall`  out  1  combinational; hold PC and IF/ID this cycle.

## Operation
- Source-use decode:
  - `use_rs1` = optype bits 0,1,2,3,4,6.
  - `use_rs2` = optype bits 0,3,4.
- Load-use hazard:
  - `lu` = `id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((use_rs1 & id_rs1 == ex_rd) | (use_rs2 & id_rs2 == ex_rd))`.
- `hazard_stall` = `(lu & ~flush) | ex_stall`.
- Per-edge update, highest priority first:
  1. `flush`: load a bubble.
  2. `ex_stall`: hold all `ex_*` unchanged.
  3. `lu`: load a bubble. The ID instruction remains in IF/ID because `hazard_stall` is high.
  4. `id_valid = 0`: load a bubble.
  5. Otherwise: capture all `id_*` fields and set `ex_valid = 1`.
- Bubble definition:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`, `ex_jump`, `ex_jalr` = 0.
  - `ex_alu_op` = 0; all index, data and PC fields = 0.
- Load-use stall lasts exactly one cycle. After the bubble the load sits in MEM, `lu` drops, and the dependent instruction is captured; forwarding resolves it from there.
- `rd = x0` never causes a hazard.
- System-class instructions (bit9) use no sources and never stall.

## Timing
- Latency: one cycle from `id_*` to `ex_*`.
- `hazard_stall` is combinational from current `ex_*` and `id_*`, `flush` and `ex_stall`, with no added register. It must settle within the same cycle.
- Reset, asynchronous on `rst_n` low: all `ex_*` outputs 0 (equivalent to a bubble). `hazard_stall` then follows its combinational equation.
- Reset asserted mid-stall clears the stall state immediately. The first edge after release captures `id_*` normally.
- `flush` and `lu` in the same cycle: bubble is loaded and `hazard_stall` is not raised by `lu`.
- `flush` and `ex_stall` in the same cycle: flush wins and a bubble is loaded.
- Back-to-back loads with dependent third instruction: each dependency stalls independently, one cycle per load-use pair.

## Configuration
- `ID_EX_PERF_EN` defined:
  - Adds outputs `perf_bubbles` [31:0] and `perf_flushes` [31:0], both reset to 0.
  - `perf_bubbles` increments on each edge where a load-use bubble is loaded.
  - `perf_flushes` increments on each edge where `flush` is applied.
  - Both counters are saturating at 32'hFFFF_FFFF and neither increments while `rst_n` is low.
- `ID_EX_PERF_EN` undefined: the ports and counters are absent; functional behaviour is identical.

## Test plan
- Reset, then `id_valid=1` ADD (optype 0x001, rd=5, x=3, y=4, alu_op=0) → next edge: `ex_valid=1`, `ex_rd=5`, `ex_x=3`, `ex_y=4`, `ex_reg_write=1`.
- LW rd=6 captured, then ADD rs1=6 in ID → `hazard_stall=1` for one cycle, bubble in EX (`ex_valid=0`), ADD captured on the following edge, `hazard_stall=0`.
- LW rd=0 followed by ADD rs1=0 → `hazard_stall=0`, no bubble. LW rd=7 followed by LUI (optype 0x080) rd=7 → no stall.
- `flush=1` with valid SW in ID → next edge `ex_valid=0`, `ex_mem_write=0`; with `ID_EX_PERF_EN`, `perf_flushes` 0→1.
- `ex_stall=1` for 3 cycles with a valid instruction in EX → `ex_*` unchanged all 3 cycles, `hazard_stall=1`. Release → new instruction is captured on the next edge.
- Assert `rst_n=0` asynchronously mid-cycle during a load-use stall → all `ex_*` = 0 immediately, before the next clock edge. With `ID_EX_PERF_EN`, `perf_bubbles` reads 0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Signal bundle between the decode stage, the ID/EX register and
//            the EX stage. Carries the decoded control word and operands in
//            (id_*), the registered copy out (ex_*), the flush/stall controls
//            and the combinational hazard stall back to IF/ID and the PC.
// Modports : master - decode/EX side: drives id_*, flush, ex_stall;
//                     observes ex_*, hazard_stall
//            slave  - ID/EX register: the reverse directions
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    // decode side
    logic            id_valid;
    logic [10:0]     id_optype;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_pc;
    logic [3:0]      id_alu_op;
    logic            id_alu_src;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            id_branch;
    logic            id_jump;
    logic            id_jalr;
    logic [XLEN-1:0] id_x;
    logic [XLEN-1:0] id_y;
    logic [XLEN-1:0] id_write_data;
    logic [XLEN-1:0] id_imm;

    // pipeline control
    logic            flush;
    logic            ex_stall;
    logic            hazard_stall;

    // EX side
    logic            ex_valid;
    logic [10:0]     ex_optype;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic [3:0]      ex_alu_op;
    logic            ex_alu_src;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_jalr;
    logic [XLEN-1:0] ex_x;
    logic [XLEN-1:0] ex_y;
    logic [XLEN-1:0] ex_write_data;
    logic [XLEN-1:0] ex_imm;

    modport master (
        output id_valid, id_optype, id_rs1, id_rs2, id_rd, id_pc, id_alu_op,
               id_alu_src, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch, id_jump, id_jalr,
               id_x, id_y, id_write_data, id_imm,
               flush, ex_stall,
        input  ex_valid, ex_optype, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_alu_op,
               ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch, ex_jump, ex_jalr,
               ex_x, ex_y, ex_write_data, ex_imm,
               hazard_stall
    );

    modport slave (
        input  id_valid, id_optype, id_rs1, id_rs2, id_rd, id_pc, id_alu_op,
               id_alu_src, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_branch, id_jump, id_jalr,
               id_x, id_y, id_write_data, id_imm,
               flush, ex_stall,
        output ex_valid, ex_optype, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_alu_op,
               ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch, ex_jump, ex_jalr,
               ex_x, ex_y, ex_write_data, ex_imm,
               hazard_stall
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register of the 5-stage RV32I core with load-use
//            hazard detection and bubble insertion. Update priority per edge:
//            flush > ex_stall (hold) > load-use (bubble) > !id_valid (bubble)
//            > capture.
// Ports    : clk          - core clock, rising edge
//            rst_n        - asynchronous active-low reset (ex_* -> 0)
//            bus          - id_ex_stage_if.slave: id_* in, ex_* out,
//                           flush / ex_stall in, hazard_stall out
//            perf_bubbles - (ID_EX_PERF_EN) load-use bubbles inserted
//            perf_flushes - (ID_EX_PERF_EN) flushes applied
// Options  : ID_EX_PERF_EN - adds saturating 32-bit performance counters
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    id_ex_stage_if.slave     bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]      perf_bubbles,
    output logic [31:0]      perf_flushes
`endif
);

    // Optype classes that read rs1: R, I-ALU, load, store, branch, JALR.
    localparam logic [10:0] c_use_rs1_mask = 11'h05F;
    // Optype classes that read rs2: R, store, branch.
    localparam logic [10:0] c_use_rs2_mask = 11'h019;

    typedef struct packed {
        logic            valid;
        logic [10:0]     optype;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] imm;
    } ex_word_t;

    ex_word_t ex_q;
    ex_word_t ex_d;
    ex_word_t id_word;

    logic use_rs1;
    logic use_rs2;
    logic lu;

    assign id_word = '{
        valid:      1'b1,
        optype:     bus.id_optype,
        rs1:        bus.id_rs1,
        rs2:        bus.id_rs2,
        rd:         bus.id_rd,
        pc:         bus.id_pc,
        alu_op:     bus.id_alu_op,
        alu_src:    bus.id_alu_src,
        reg_write:  bus.id_reg_write,
        mem_read:   bus.id_mem_read,
        mem_write:  bus.id_mem_write,
        mem_to_reg: bus.id_mem_to_reg,
        branch:     bus.id_branch,
        jump:       bus.id_jump,
        jalr:       bus.id_jalr,
        x:          bus.id_x,
        y:          bus.id_y,
        write_data: bus.id_write_data,
        imm:        bus.id_imm
    };

    // ------------------------------------------------------------------------
    // Load-use detection against the instruction currently in EX.
    // ------------------------------------------------------------------------
    assign use_rs1 = |(bus.id_optype & c_use_rs1_mask);
    assign use_rs2 = |(bus.id_optype & c_use_rs2_mask);

    assign lu = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                ((use_rs1 & (bus.id_rs1 == ex_q.rd)) |
                 (use_rs2 & (bus.id_rs2 == ex_q.rd)));

    // A flush kills the dependent instruction anyway, so it must not stall.
    assign bus.hazard_stall = (lu & ~bus.flush) | bus.ex_stall;

    // ------------------------------------------------------------------------
    // Next-state selection. A bubble is the all-zero word.
    // ------------------------------------------------------------------------
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.ex_stall) begin
            ex_d = ex_q;
        end else if (lu) begin
            ex_d = '0;
        end else if (!bus.id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = id_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_optype     = ex_q.optype;
    assign bus.ex_rs1        = ex_q.rs1;
    assign bus.ex_rs2        = ex_q.rs2;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_jalr       = ex_q.jalr;
    assign bus.ex_x          = ex_q.x;
    assign bus.ex_y          = ex_q.y;
    assign bus.ex_write_data = ex_q.write_data;
    assign bus.ex_imm        = ex_q.imm;

`ifdef ID_EX_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating event counters. A load-use bubble is only counted when it is
    // actually loaded, i.e. neither flush nor ex_stall takes precedence.
    // ------------------------------------------------------------------------
    logic [31:0] perf_bubbles_q;
    logic [31:0] perf_flushes_q;
    logic        lu_bubble;

    assign lu_bubble = lu & ~bus.flush & ~bus.ex_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            if (lu_bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
            if (bus.flush && (perf_flushes_q != 32'hFFFF_FFFF)) begin
                perf_flushes_q <= perf_flushes_q + 32'd1;
            end
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule
`default_nettype wire
